wb_uart_tracer: RTL and testbench
=================================

WB_UART_TRACER -- requirements
Module: wb_uart_tracer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving UART bit period in clk cycles (50 MHz / 115200).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the FIFO entry count (power of two, 2..16).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wb_write_en  input  1  writeback stage register-write enable.
REQ-006 wb_rd  input  5  writeback destination register.
REQ-007 wb_data  input  32  writeback result (rd data mux output).
REQ-008 uart_tx  output  1  serial trace line, 8N1, idle high.
REQ-009 busy  output  1  high while a frame is being transmitted.
REQ-010 fifo_count  output  5  current FIFO occupancy, 0..DEPTH.
REQ-011 overflow  output  1  sticky; set on any dropped record.
REQ-012 drop_count  output  8  dropped records, saturating at 255.

Function
REQ-013 Capture: each cycle with wb_write_en=1 and wb_rd!=0 SHALL form a record {wb_rd, wb_data}; wb_rd=0 writes SHALL be ignored.
REQ-014 Push: a record SHALL be written at the edge ending its capture cycle; fifo_count reflects it the next cycle.
REQ-015 Pop: when the serializer is in IDLE and fifo_count!=0, it SHALL pop the oldest record and load it at the same edge.
REQ-016 Full: a capture while full and no pop that cycle SHALL be dropped, set overflow, and increment drop_count (saturating at 255).
REQ-017 Simultaneous: a capture while full with a pop in the same cycle SHALL be accepted; count unchanged.
REQ-018 Pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-019 Frame: 6 bytes in order 0xA5, {3'b000, rd}, data[31:24], data[23:16], data[15:8], data[7:0].
REQ-020 Byte: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-021 FSM states: IDLE, START, DATA, STOP. Transitions:
- IDLE->START on pop.
- START->DATA after one bit period.
- DATA->STOP after 8 bit periods.
- STOP->START if bytes remain in the frame.
- STOP->IDLE after byte 5.
REQ-022 Bytes within a frame SHALL be back-to-back with no idle gap; consecutive frames SHALL be separated by exactly one IDLE cycle.
REQ-023 Latency: capture in cycle N with empty FIFO and idle serializer -> pop at end of N+1 -> uart_tx low from N+2.
REQ-024 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 Frame length SHALL be 60*CLKS_PER_BIT cycles.

Reset
REQ-026 rst_n=0 at an edge SHALL empty the FIFO; FSM to IDLE; bit and byte counters 0; uart_tx=1; busy=0; fifo_count=0; overflow=0; drop_count=0.
REQ-027 Reset mid-frame SHALL abort the frame; uart_tx high the next cycle; the partial frame is not resumed.
REQ-028 Captures during reset SHALL be discarded.

Structure
REQ-029 Shared package SHALL hold the state enum, SYNC_BYTE=8'hA5, FRAME_BYTES=6, and the record typedef (rd 5 + data 32).
REQ-030 FIFO SHALL be a separate sub-module trace_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-031 The top level SHALL instantiate trace_fifo and the serializer FSM; no other sub-modules.

Verification (CLKS_PER_BIT=4, DEPTH=8)
REQ-032 Single write: wb_rd=5, wb_data=0xDEADBEEF, 1 cycle -> uart_tx low 2 cycles later; bytes decode A5 05 DE AD BE EF; busy high exactly 240 cycles.
REQ-033 x0 filter: wb_rd=0, wb_data=0x12345678 -> no frame; fifo_count stays 0.
REQ-034 Burst: 10 consecutive captures rd=1..10 -> 1 popped immediately, 8 buffered, rd=10 dropped; overflow=1; drop_count=1; frames for rd 1..9 in order.
REQ-035 Full with simultaneous pop: fill FIFO to 8 with serializer ending STOP of byte 5, capture on the pop cycle -> accepted, drop_count unchanged.
REQ-036 Reset mid-frame: assert rst_n=0 during byte 3 of a frame -> uart_tx=1, fifo_count=0, overflow=0 next cycle; no further edges.
REQ-037 Saturation: 300 drops -> drop_count=255, overflow stays 1.

Source files
------------

// File: rtl/wb_uart_tracer_pkg.sv
// Shared types and constants for the writeback trace serializer.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package wb_uart_tracer_pkg;

    // Serializer states; encoding kept explicit so waveforms stay readable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 6;

    // One captured register write.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_rec_t;

    // Byte idx of the on-wire frame: sync, rd, then data MSB first.
    function automatic logic [7:0] frame_byte(input trace_rec_t rec, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {3'b000, rec.rd};
            3'd2:    b = rec.data[31:24];
            3'd3:    b = rec.data[23:16];
            3'd4:    b = rec.data[15:8];
            3'd5:    b = rec.data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO, power-of-two depth, combinational head read.
// Latency: a push is visible in o_count / o_pop_dat the cycle after its edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_tracer.sv
// Captures writeback register writes and streams each as a 6-byte 8N1 UART frame.
// Latency: capture in cycle N -> FIFO pop at end of N+1 -> start bit on uart_tx from N+2.
// Backpressure: none upstream; captures arriving at a full FIFO are dropped and counted.
module wb_uart_tracer
    import wb_uart_tracer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_write_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        uart_tx,
    output logic        busy,
    output logic [4:0]  fifo_count,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int              FCW      = $clog2(DEPTH + 1);
    localparam logic [2:0]      BYTE_LAST = 3'(FRAME_BYTES - 1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       r_byte_idx;
    logic [7:0]       r_shift;
    trace_rec_t       r_rec;
    logic             r_tx;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    trace_rec_t       w_cap_rec;
    trace_rec_t       w_head_rec;
    logic             w_cap;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [FCW-1:0]   w_count;
    logic             w_bit_end;

    // Writes to x0 carry no architectural effect and are not traced.
    assign w_cap     = wb_write_en && (wb_rd != 5'd0);
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_drop    = w_cap && w_full && !w_pop;
    assign w_push    = w_cap && !w_drop;
    assign w_cap_rec = '{rd: wb_rd, data: wb_data};
    assign w_bit_end = (r_clk_cnt == BIT_LAST);

    assign uart_tx    = r_tx;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = 5'(w_count);
    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_cap_rec),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head_rec),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Serializer: the line level is registered alongside each state change so it never glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_rec      <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_rec      <= w_head_rec;
                        r_byte_idx <= '0;
                        r_shift    <= SYNC_BYTE;
                        r_state    <= ST_START;
                        r_tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx == BYTE_LAST) begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_shift    <= frame_byte(r_rec, r_byte_idx + 3'd1);
                            r_state    <= ST_START;
                            r_tx       <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Drop bookkeeping: overflow is sticky, the counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_uart_tracer.sv
// Self-checking bench: queue-based tracer model plus an independent UART line decoder.
// Latency: model advances once per clock edge; outputs compared 1 time unit after it.
// Backpressure: drops predicted from queue occupancy and frame-time occupancy of the line.
module tb_wb_uart_tracer;

    localparam int CPB       = 4;
    localparam int DEP       = 8;
    localparam int FRAME_CYC = 60 * CPB;

    logic        clk;
    logic        rst_n;
    logic        wb_write_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        uart_tx;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    // Model: pending records, cycles left on the current frame, drop statistics.
    logic [36:0] m_q[$];
    int          m_left;
    int          m_drops;
    bit          m_ovf;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    bit          rx_act;
    int          rx_cnt;
    logic [7:0]  rx_byte;

    wb_uart_tracer #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_write_en (wb_write_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART receiver: samples mid-bit on the falling edge, collects bytes into rx_q.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) begin
                checks++;
                if (uart_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL start_bit: uart_tx=%b required 0", uart_tx);
                    rx_act = 1'b0;
                end
            end else if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
                rx_byte[3'((rx_cnt - CPB) / CPB)] = uart_tx;
            end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                checks++;
                if (uart_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit: uart_tx=%b required 1", uart_tx);
                end
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    end

    // One clock edge: advance the model with the inputs the DUT sees, then settle.
    task automatic step();
        logic [36:0] rec;
        bit pop, full, cap;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_left  = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            pop  = (m_left == 0) && (m_q.size() != 0);
            full = (m_q.size() == DEP);
            cap  = wb_write_en && (wb_rd != 5'd0);
            if (pop) begin
                rec = m_q.pop_front();
                exp_q.push_back(8'hA5);
                exp_q.push_back({3'b000, rec[36:32]});
                exp_q.push_back(rec[31:24]);
                exp_q.push_back(rec[23:16]);
                exp_q.push_back(rec[15:8]);
                exp_q.push_back(rec[7:0]);
                m_left = FRAME_CYC;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (cap) begin
                if (!full || pop) begin
                    m_q.push_back({wb_rd, wb_data});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        #1;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((m_left != 0 || m_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        repeat (4) step();
        ok = (n < 3000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks += 5;
        if (uart_tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (fifo_count !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        if (drop_count !== 8'd0)  begin errors++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [7:0] want [6];
        int bc;
        bit ok;
        want = '{8'hA5, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        wb_write_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_write_en = 1'b0;
        checks += 2;
        if (uart_tx !== 1'b1)    begin errors++; $display("FAIL single_tx_n1: got %b want 1", uart_tx); end
        if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count_n1: got %0d want 1", fifo_count); end
        step();
        checks += 2;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL single_tx_n2: got %b want 0", uart_tx); end
        if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy_n2: got %b want 1", busy); end
        bc = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy === 1'b1) bc++;
        end
        checks++;
        if (bc != FRAME_CYC) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", bc, FRAME_CYC); end
        drain(ok);
        checks++;
        if (rx_q.size() != 6) begin errors++; $display("FAIL single_len: got %0d bytes want 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== want[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], want[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_x0_filter();
        wb_write_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
        for (int i = 0; i < 20; i++) begin
            step();
            checks += 2;
            if (fifo_count !== 5'd0) begin errors++; $display("FAIL x0_count: got %0d want 0", fifo_count); end
            if (busy !== 1'b0)       begin errors++; $display("FAIL x0_busy: got %b want 0", busy); end
        end
        wb_write_en = 1'b0;
        repeat (10) step();
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL x0_frame: got %0d bytes want 0", rx_q.size()); end
    endtask

    task automatic test_burst();
        bit ok;
        for (int i = 1; i <= 10; i++) begin
            wb_write_en = 1'b1; wb_rd = 5'(i); wb_data = $urandom;
            step();
            checks++;
            if (fifo_count !== 5'(m_q.size())) begin errors++; $display("FAIL burst_count: got %0d want %0d", fifo_count, m_q.size()); end
        end
        wb_write_en = 1'b0;
        checks += 3;
        if (overflow !== 1'b1)   begin errors++; $display("FAIL burst_ovf: got %b want 1", overflow); end
        if (drop_count !== 8'd1) begin errors++; $display("FAIL burst_drops: got %0d want 1", drop_count); end
        if (fifo_count !== 5'd8) begin errors++; $display("FAIL burst_full: got %0d want 8", fifo_count); end
        drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL burst_drain: timeout"); end
        if (rx_q.size() != 54 || exp_q.size() != 54) begin
            errors++; $display("FAIL burst_len: got %0d bytes want 54 (model %0d)", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_pop();
        int  n = 0;
        int  prev;
        bit  ok;
        for (int i = 0; i < 9; i++) begin
            wb_write_en = 1'b1; wb_rd = 5'(11 + i); wb_data = $urandom;
            step();
        end
        wb_write_en = 1'b0;
        while (m_left != 0 && n < 400) begin step(); n++; end
        checks += 3;
        if (n >= 400) begin errors++; $display("FAIL fullpop_wait: timeout"); end
        if (fifo_count !== 5'd8) begin errors++; $display("FAIL fullpop_pre_count: got %0d want 8", fifo_count); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL fullpop_idle: got %b want 0", busy); end
        prev = m_drops;
        wb_write_en = 1'b1; wb_rd = 5'd20; wb_data = $urandom;
        step();
        wb_write_en = 1'b0;
        checks += 3;
        if (drop_count !== 8'(prev)) begin errors++; $display("FAIL fullpop_drops: got %0d want %0d", drop_count, prev); end
        if (fifo_count !== 5'd8)     begin errors++; $display("FAIL fullpop_count: got %0d want 8", fifo_count); end
        if (busy !== 1'b1)           begin errors++; $display("FAIL fullpop_busy: got %b want 1", busy); end
        drain(ok);
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL fullpop_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            wb_write_en = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            step();
        end
        wb_write_en = 1'b0;
        // Elapsed 140 cycles into the frame lands inside byte 3.
        while (m_left != FRAME_CYC - 140 && n < 400) begin step(); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL rstmid_wait: timeout"); end
        rst_n = 1'b0;
        wb_write_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFEF00D;
        step();
        wb_write_en = 1'b0;
        checks += 4;
        if (uart_tx !== 1'b1)    begin errors++; $display("FAIL rstmid_tx: got %b want 1", uart_tx); end
        if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        if (overflow !== 1'b0)   begin errors++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if (uart_tx !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL rstmid_quiet: tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
            end
        end
        checks += 2;
        if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_post_count: got %0d want 0", fifo_count); end
        if (rx_q.size() != 0)    begin errors++; $display("FAIL rstmid_bytes: got %0d want 0", rx_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 2000; i++) begin
            wb_write_en = ($urandom_range(0, 99) < 4);
            wb_rd       = 5'($urandom_range(0, 31));
            wb_data     = $urandom;
            step();
            checks += 4;
            if (busy !== (m_left != 0))        begin errors++; $display("FAIL rand_busy: got %b want %b", busy, m_left != 0); end
            if (fifo_count !== 5'(m_q.size())) begin errors++; $display("FAIL rand_count: got %0d want %0d", fifo_count, m_q.size()); end
            if (overflow !== m_ovf)            begin errors++; $display("FAIL rand_ovf: got %b want %b", overflow, m_ovf); end
            if (drop_count !== 8'(m_drops))    begin errors++; $display("FAIL rand_drops: got %0d want %0d", drop_count, m_drops); end
        end
        wb_write_en = 1'b0;
        drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rand_drain: timeout"); end
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 330; i++) begin
            wb_write_en = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            step();
        end
        wb_write_en = 1'b0;
        checks += 3;
        if (drop_count !== 8'd255)      begin errors++; $display("FAIL sat_drops: got %0d want 255", drop_count); end
        if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL sat_model: got %0d want %0d", drop_count, m_drops); end
        if (overflow !== 1'b1)          begin errors++; $display("FAIL sat_ovf: got %b want 1", overflow); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rx_q.delete(); exp_q.delete();
        step();
    endtask

    initial begin
        rst_n = 1'b0; wb_write_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        m_left = 0; m_drops = 0; m_ovf = 1'b0;
        rx_act = 1'b0; rx_cnt = 0; rx_byte = 8'd0;
        test_reset();
        test_single();
        test_x0_filter();
        test_burst();
        test_full_pop();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
